aes128_decrypt_iter: RTL and testbench

- Iterative AES-128 decryption core. It is the inverse of the team's iterative AES-128 encryption datapath.
- It takes a 128-bit cipher key and a ciphertext block under a start/busy/done handshake and returns the FIPS-197 plaintext.
- It computes one round per clock and generates the key schedule on the fly:
  - a forward expansion first reaches round key 10;
  - an inverse expansion then steps back down to round key 0.
- It sits beside the encrypt core so the top level supports both directions.

---
 rtl/aes128_decrypt_iter_if.sv | 20 ++
 rtl/aes128_decrypt_iter.sv | 194 +++++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/aes128_decrypt_iter_if.sv
// Request/response bundle for the iterative AES-128 decrypt core.
// The master issues start with key and ciphertext. The core returns busy, done and plain_text.
interface aes128_decrypt_iter_if;
  logic         start;
  logic [127:0] cipher_key;
  logic [127:0] cipher_text;
  logic         busy;
  logic         done;
  logic [127:0] plain_text;

  modport master (
    output start, cipher_key, cipher_text,
    input  busy, done, plain_text
  );

  modport slave (
    input  start, cipher_key, cipher_text,
    output busy, done, plain_text
  );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption: one round per clock, with the key schedule expanded on the fly.
// The schedule first runs forward to K10, then steps back down to K0.
module aes128_decrypt_iter (
  input  logic                 clk,
  input  logic                 reset,
  aes128_decrypt_iter_if.slave bus
);

  localparam int NR = 10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // Byte x of each table is found at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // SubWord(RotWord(w)).
  function automatic logic [31:0] rot_sub(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // InvMixColumns on one column; the 09/0b/0d/0e multiples are built from a single xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a  = col[31-8*i -: 8];
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows followed by InvSubBytes. Row r rotates right by r, so its source column is (c - r) mod 4.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
    return o;
  endfunction

  logic [1:0]   fsm_q;
  logic [3:0]   rcnt_q;
  logic [127:0] key_q;
  logic [127:0] st_q;
  logic [127:0] pt_q;
  logic         busy_q;
  logic         done_q;

  logic [31:0]  kw3_prev, sub_in, sw;
  logic [31:0]  fw0, fw1, fw2, fw3;
  logic [7:0]   rc;
  logic [127:0] key_fwd, key_bwd, core, mixed;

  // One SubWord unit serves both directions. Forward expansion uses w3 of the current key.
  // Backward expansion uses w3 of the previous key, which is w3' ^ w2'.
  // NOTE: every always_comb output is assigned on every path, so no latches can be inferred.
  always_comb begin
    kw3_prev = key_q[31:0] ^ key_q[63:32];
    sub_in   = (fsm_q == S_KEYEXP) ? key_q[31:0] : kw3_prev;
    rc       = (fsm_q == S_KEYEXP) ? rcon(rcnt_q) : rcon(rcnt_q + 4'd1);
    sw       = rot_sub(sub_in) ^ {rc, 24'h000000};
    fw0      = key_q[127:96] ^ sw;
    fw1      = key_q[95:64]  ^ fw0;
    fw2      = key_q[63:32]  ^ fw1;
    fw3      = key_q[31:0]   ^ fw2;
    key_fwd  = {fw0, fw1, fw2, fw3};
    key_bwd  = {key_q[127:96] ^ sw,
                key_q[95:64]  ^ key_q[127:96],
                key_q[63:32]  ^ key_q[95:64],
                kw3_prev};
    core     = inv_shift_sub(st_q) ^ key_bwd;
    mixed    = {inv_mix_col(core[127:96]), inv_mix_col(core[95:64]),
                inv_mix_col(core[63:32]),  inv_mix_col(core[31:0])};
  end

  // NOTE: state registers use non-blocking assignments, so every register in the block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= S_IDLE;
      rcnt_q <= '0;
      key_q  <= '0;
      st_q   <= '0;
      pt_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (bus.start) begin
            key_q  <= bus.cipher_key;
            st_q   <= bus.cipher_text;
            rcnt_q <= 4'd1;
            busy_q <= 1'b1;
            fsm_q  <= S_KEYEXP;
          end
        end
        S_KEYEXP: begin
          key_q <= key_fwd;
          if (rcnt_q == 4'(NR)) begin
            st_q   <= st_q ^ key_fwd;
            rcnt_q <= 4'(NR - 1);
            fsm_q  <= S_ROUND;
          end else begin
            rcnt_q <= rcnt_q + 4'd1;
          end
        end
        S_ROUND: begin
          key_q  <= key_bwd;
          st_q   <= mixed;
          rcnt_q <= rcnt_q - 4'd1;
          if (rcnt_q == 4'd1) fsm_q <= S_FINISH;
        end
        S_FINISH: begin
          key_q  <= key_bwd;
          pt_q   <= core;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          fsm_q  <= S_IDLE;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.plain_text = pt_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed bench for aes128_decrypt_iter, using known-answer vectors and multi-cycle handshake corner cases.
module tb_aes128_decrypt_iter;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] k10;
    logic         has_k10;
  } vec_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  aes128_decrypt_iter_if bus ();

  aes128_decrypt_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts one operation from the current cycle. The task returns inside the done cycle, or after the cycle budget runs out.
  task automatic run_op(input vec_t v, input string tag, input int glitch,
                        input logic [127:0] prev_pt, input logic chk_prev);
    int cyc;
    int busy_bad;
    int held_bad;
    bus.start       = 1'b1;
    bus.cipher_key  = v.key;
    bus.cipher_text = v.ct;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.cipher_key  = ~v.key;
    bus.cipher_text = ~v.ct;
    cyc = 1; busy_bad = 0; held_bad = 0;
    while (!bus.done && cyc < 40) begin
      if (!bus.busy) busy_bad++;
      if (chk_prev && bus.plain_text !== prev_pt) held_bad++;
      if (cyc == 11 && v.has_k10) check({tag, " key_k10"}, dut.key_q, v.k10);
      bus.start = (glitch != 0 && (cyc == glitch || cyc == glitch + 10));
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 128'(cyc), 128'd21);
    check({tag, " done"}, 128'(bus.done), 128'd1);
    check({tag, " busy_window"}, 128'(busy_bad), 128'd0);
    check({tag, " busy_at_done"}, 128'(bus.busy), 128'd0);
    check({tag, " plain_text"}, bus.plain_text, v.pt);
    check({tag, " key_k0"}, dut.key_q, v.key);
    if (chk_prev) check({tag, " prev_held"}, 128'(held_bad), 128'd0);
  endtask

  vec_t vecs [3];
  vec_t c1, ab;
  int   d0;

  initial begin
    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt: 128'h00112233445566778899aabbccddeeff, k10: 128'h13111d7fe3944a17f307a78b4d2b30c5, has_k10: 1'b1};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734, k10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, has_k10: 1'b1};
    vecs[2] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                pt: 128'h0, k10: 128'h0, has_k10: 1'b0};
    c1 = vecs[0];
    ab = vecs[1];

    reset = 1'b1;
    bus.start = 1'b0;
    bus.cipher_key = '0;
    bus.cipher_text = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 128'(bus.busy), 128'd0);
    check("reset done", 128'(bus.done), 128'd0);
    check("reset plain_text", bus.plain_text, 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i), 0, '0, 1'b0);
      @(posedge clk); #1;
      check($sformatf("vec%0d done_pulse", i), 128'(bus.done), 128'd0);
    end

    // Back-to-back: the second start is issued in the first operation's done cycle.
    run_op(c1, "b2b_first", 0, '0, 1'b0);
    run_op(ab, "b2b_second", 0, c1.pt, 1'b1);
    @(posedge clk); #1;

    // Garbage starts in cycles 5 and 15 of the run must be ignored.
    d0 = done_cnt;
    run_op(c1, "ignored_start", 5, '0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("ignored_start done_count", 128'(done_cnt - d0), 128'd1);

    // Reset in cycle 12 aborts the operation.
    bus.start = 1'b1;
    bus.cipher_key = c1.key;
    bus.cipher_text = c1.ct;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", 128'(bus.busy), 128'd0);
    check("abort plain_text", bus.plain_text, 128'd0);
    d0 = done_cnt;
    repeat (25) @(posedge clk);
    #1;
    check("abort no_done", 128'(done_cnt - d0), 128'd0);
    check("abort plain_text_held", bus.plain_text, 128'd0);
    check("abort idle_busy", 128'(bus.busy), 128'd0);
    run_op(c1, "after_abort", 0, '0, 1'b0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
